// File: rtl/pdm_value_sequencer.sv
// Double-buffered PDM value sequencer: values are captured into a shadow buffer and applied on frame ticks.
// Optional PDM_SLEW_LIMIT_EN macro limits the per-tick change of each active value to SLEW_STEP.
module pdm_value_sequencer #(
  parameter int NUM_CHANNELS    = 4,
  parameter int CFG_DATA_WIDTH  = 16,
  parameter int PDM_VALUE_WIDTH = 11,
  parameter int SLEW_STEP       = 16
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic                                     enable,
  input  logic [15:0]                              frame_len,
  input  logic [NUM_CHANNELS*CFG_DATA_WIDTH-1:0]   pdm_nxt,
  input  logic                                     nxt_valid,
  output logic                                     nxt_ready,
  output logic [NUM_CHANNELS*PDM_VALUE_WIDTH-1:0]  pdm_values,
  output logic                                     update_tick,
  output logic [15:0]                              missed_cnt,
  output logic [NUM_CHANNELS*CFG_DATA_WIDTH-1:0]   pdm_sts
);

  localparam int VW = PDM_VALUE_WIDTH;
  localparam int DW = CFG_DATA_WIDTH;

  typedef enum logic {EMPTY, PENDING} buf_state_t;

  buf_state_t                     state;
  logic [NUM_CHANNELS*VW-1:0]     shadow;
  logic [NUM_CHANNELS*VW-1:0]     shadow_sat;
  logic [NUM_CHANNELS*VW-1:0]     active;
  logic [NUM_CHANNELS*VW-1:0]     next_active;
  logic [15:0]                    counter;
  logic [15:0]                    tick_limit;
  logic                           tick;
  logic                           load_active;

  // A frame length of 0 behaves like 1, so a tick is produced every cycle.
  assign tick_limit = (frame_len == 16'd0) ? 16'd0 : frame_len - 16'd1;
  assign tick       = enable && (counter >= tick_limit);
  assign nxt_ready  = (state == EMPTY);
  assign pdm_values = active;

`ifdef PDM_SLEW_LIMIT_EN
  localparam int VMAX      = (1 << VW) - 1;
  localparam int STEP_CLIP = (SLEW_STEP > VMAX) ? VMAX : SLEW_STEP;
  localparam logic [VW-1:0] STEP_V = VW'(STEP_CLIP);

  logic [NUM_CHANNELS*VW-1:0] target;
  logic [NUM_CHANNELS*VW-1:0] step_target;

  assign step_target = (state == PENDING) ? shadow : target;
  assign load_active = tick;
`else
  logic unused_slew;

  assign unused_slew = ^SLEW_STEP;
  assign next_active = shadow;
  assign load_active = tick && (state == PENDING);
`endif

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [DW-1:0] word;

    assign word = pdm_nxt[ch*DW +: DW];
    assign shadow_sat[ch*VW +: VW] = ((word >> VW) != '0) ? {VW{1'b1}} : word[VW-1:0];
    assign pdm_sts[ch*DW +: DW] = DW'(active[ch*VW +: VW]);

`ifdef PDM_SLEW_LIMIT_EN
    logic [VW-1:0] cur;
    logic [VW-1:0] tgt;

    // Step toward the target without overshooting it.
    assign cur = active[ch*VW +: VW];
    assign tgt = step_target[ch*VW +: VW];
    assign next_active[ch*VW +: VW] =
      (tgt > cur) ? (((tgt - cur) > STEP_V) ? cur + STEP_V : tgt)
                  : (((cur - tgt) > STEP_V) ? cur - STEP_V : tgt);
`endif
  end

  // A tick consumes the shadow state as it was before this edge, so a capture
  // landing on the same edge stays pending for the following frame.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= EMPTY;
      shadow      <= '0;
      active      <= '0;
      counter     <= '0;
      update_tick <= 1'b0;
      missed_cnt  <= '0;
`ifdef PDM_SLEW_LIMIT_EN
      target      <= '0;
`endif
    end else begin
      update_tick <= tick;
      counter     <= (!enable || tick) ? 16'd0 : counter + 16'd1;

      if (load_active) begin
        active <= next_active;
      end

      if (tick) begin
`ifdef PDM_SLEW_LIMIT_EN
        target <= step_target;
`endif
        if (state == PENDING) begin
          state <= EMPTY;
        end else if (missed_cnt != 16'hFFFF) begin
          missed_cnt <= missed_cnt + 16'd1;
        end
      end

      if (nxt_valid && state == EMPTY) begin
        shadow <= shadow_sat;
        state  <= PENDING;
      end
    end
  end

endmodule
